tl_light_monitor: RTL and testbench

Passive checker for the red/yellow/green outputs of the traffic-light sequencer. It samples the three light lines every clock and tracks the current phase, measuring how long each phase lasts. It flags non-one-hot encodings, illegal phase orders and dwell-time violations with sticky error flags, and counts completed light cycles. It sits beside the sequencer in the same clock domain and is used both in silicon, as a safety monitor, and in benches, as a scoreboard.

---
 rtl/tl_light_monitor_if.sv | 49 ++++
 rtl/tl_light_monitor.sv | 177 +++++++++++++++++
 tb/tb_tl_light_monitor.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/tl_light_monitor_if.sv
// Light-line bundle between a traffic-light sequencer and its monitor.
// Latency: none, wires only. Backpressure: none, the monitor is passive.
// Ports: red_i/yellow_i/green_i/clr_i driven by master; status outputs driven by slave (monitor).
// Build option TL_MON_MAXDWELL_EN adds max_red_o/max_green_o/max_yellow_o.
interface tl_light_monitor_if #(
  parameter int CNT_W = 8
);
  logic             red_i;
  logic             yellow_i;
  logic             green_i;
  logic             clr_i;
  logic             locked_o;
  logic [1:0]       phase_o;
  logic [CNT_W-1:0] dwell_o;
  logic [15:0]      cycles_o;
  logic             err_onehot_o;
  logic             err_seq_o;
  logic             err_dwell_o;
  logic             err_any_o;
`ifdef TL_MON_MAXDWELL_EN
  logic [CNT_W-1:0] max_red_o;
  logic [CNT_W-1:0] max_green_o;
  logic [CNT_W-1:0] max_yellow_o;

  modport master (
    output red_i, yellow_i, green_i, clr_i,
    input  locked_o, phase_o, dwell_o, cycles_o,
    input  err_onehot_o, err_seq_o, err_dwell_o, err_any_o,
    input  max_red_o, max_green_o, max_yellow_o
  );
  modport slave (
    input  red_i, yellow_i, green_i, clr_i,
    output locked_o, phase_o, dwell_o, cycles_o,
    output err_onehot_o, err_seq_o, err_dwell_o, err_any_o,
    output max_red_o, max_green_o, max_yellow_o
  );
`else
  modport master (
    output red_i, yellow_i, green_i, clr_i,
    input  locked_o, phase_o, dwell_o, cycles_o,
    input  err_onehot_o, err_seq_o, err_dwell_o, err_any_o
  );
  modport slave (
    input  red_i, yellow_i, green_i, clr_i,
    output locked_o, phase_o, dwell_o, cycles_o,
    output err_onehot_o, err_seq_o, err_dwell_o, err_any_o
  );
`endif
endinterface

// File: rtl/tl_light_monitor.sv
// Passive checker of red/yellow/green light lines: phase tracking, dwell timing, sticky errors, cycle count.
// Latency: a sample at edge N shows on all outputs right after edge N; err_any_o one cycle later.
// Backpressure: none, observes every cycle and never stalls the sequencer.
// Ports: clk, rst_n (synchronous, active-low), mon (tl_light_monitor_if.slave).
// Build option TL_MON_MAXDWELL_EN adds per-phase maximum completed dwell outputs.
module tl_light_monitor #(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 255,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  tl_light_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_RED      = 2'd1,
    ST_GREEN    = 2'd2,
    ST_YELLOW   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MIN_D     = CNT_W'(MIN_DWELL);
  // One bit wider so MAX_DWELL+1 is representable even when MAX_DWELL is all-ones.
  localparam logic [CNT_W:0]   MAX_P1    = (CNT_W+1)'(MAX_DWELL + 1);
  localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] dwell_q, dwell_nxt;
  logic [15:0]      cycles_q, cycles_nxt;
  logic             ovr_done_q, ovr_done_nxt;
  logic             err_onehot_q, err_onehot_nxt;
  logic             err_seq_q, err_seq_nxt;
  logic             err_dwell_q, err_dwell_nxt;
  logic [1:0]       phase_nxt;

  logic [2:0]       smp;
  logic             smp_legal;
  state_t           smp_phase;
  state_t           succ;
  logic             locked;
  logic             stay;
  logic             advance;
  logic             seq_fault;
  logic             overstay;
  logic             short_exit;
  logic [CNT_W:0]   dwell_inc;

  assign smp = {mon.red_i, mon.yellow_i, mon.green_i};

  always_comb begin
    smp_legal = 1'b1;
    smp_phase = ST_UNLOCKED;
    case (smp)
      3'b100:  smp_phase = ST_RED;
      3'b001:  smp_phase = ST_GREEN;
      3'b010:  smp_phase = ST_YELLOW;
      default: smp_legal = 1'b0;
    endcase
  end

  always_comb begin
    succ = ST_UNLOCKED;
    case (state_q)
      ST_RED:    succ = ST_GREEN;
      ST_GREEN:  succ = ST_YELLOW;
      ST_YELLOW: succ = ST_RED;
      default:   succ = ST_UNLOCKED;
    endcase
  end

  assign locked     = (state_q != ST_UNLOCKED);
  assign stay       = locked && smp_legal && (smp_phase == state_q);
  assign advance    = locked && smp_legal && (smp_phase == succ);
  assign seq_fault  = locked && smp_legal && !stay && !advance;
  assign dwell_inc  = {1'b0, dwell_q} + {{CNT_W{1'b0}}, 1'b1};
  // ovr_done_q suppresses repeats while dwell sits saturated at MAX_DWELL = all-ones.
  assign overstay   = stay && (dwell_inc == MAX_P1) && !ovr_done_q;
  assign short_exit = advance && (dwell_q < MIN_D);

  // State register (together with the registered datapath/outputs).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_UNLOCKED;
      dwell_q          <= '0;
      cycles_q         <= '0;
      ovr_done_q       <= 1'b0;
      err_onehot_q     <= 1'b0;
      err_seq_q        <= 1'b0;
      err_dwell_q      <= 1'b0;
      mon.locked_o     <= 1'b0;
      mon.phase_o      <= 2'b00;
      mon.err_any_o    <= 1'b0;
    end else begin
      state_q          <= state_nxt;
      dwell_q          <= dwell_nxt;
      cycles_q         <= cycles_nxt;
      ovr_done_q       <= ovr_done_nxt;
      err_onehot_q     <= err_onehot_nxt;
      err_seq_q        <= err_seq_nxt;
      err_dwell_q      <= err_dwell_nxt;
      mon.locked_o     <= (state_nxt != ST_UNLOCKED);
      mon.phase_o      <= phase_nxt;
      mon.err_any_o    <= err_onehot_q | err_seq_q | err_dwell_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (smp_legal && smp_phase == ST_RED) state_nxt = ST_RED;
      end
      default: begin
        if (!smp_legal || seq_fault) state_nxt = ST_UNLOCKED;
        else if (advance)            state_nxt = succ;
        else                         state_nxt = state_q;
      end
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    dwell_nxt    = '0;
    ovr_done_nxt = 1'b0;
    cycles_nxt   = cycles_q;
    phase_nxt    = 2'b00;

    if (!locked && smp_legal && smp_phase == ST_RED) begin
      dwell_nxt = DWELL_ONE;
    end else if (stay) begin
      dwell_nxt    = (&dwell_q) ? dwell_q : dwell_inc[CNT_W-1:0];
      ovr_done_nxt = ovr_done_q | overstay;
    end else if (advance) begin
      dwell_nxt = DWELL_ONE;
    end

    if (advance && state_q == ST_YELLOW) cycles_nxt = cycles_q + 16'd1;

    case (state_nxt)
      ST_GREEN:  phase_nxt = 2'b01;
      ST_YELLOW: phase_nxt = 2'b10;
      default:   phase_nxt = 2'b00;
    endcase

    // A fresh detection wins over a simultaneous clear.
    err_onehot_nxt = !smp_legal           | (err_onehot_q & ~mon.clr_i);
    err_seq_nxt    = seq_fault            | (err_seq_q    & ~mon.clr_i);
    err_dwell_nxt  = overstay | short_exit | (err_dwell_q & ~mon.clr_i);
  end

  assign mon.dwell_o      = dwell_q;
  assign mon.cycles_o     = cycles_q;
  assign mon.err_onehot_o = err_onehot_q;
  assign mon.err_seq_o    = err_seq_q;
  assign mon.err_dwell_o  = err_dwell_q;

`ifdef TL_MON_MAXDWELL_EN
  // Longest completed dwell per phase; only successor exits count as completed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mon.max_red_o    <= '0;
      mon.max_green_o  <= '0;
      mon.max_yellow_o <= '0;
    end else if (advance) begin
      case (state_q)
        ST_RED:    if (dwell_q > mon.max_red_o)    mon.max_red_o    <= dwell_q;
        ST_GREEN:  if (dwell_q > mon.max_green_o)  mon.max_green_o  <= dwell_q;
        ST_YELLOW: if (dwell_q > mon.max_yellow_o) mon.max_yellow_o <= dwell_q;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_tl_light_monitor.sv
// Directed bench for tl_light_monitor: instance a with default limits, instance b with MIN_DWELL=2, MAX_DWELL=3.
// Inputs change after each rising edge; outputs are sampled 1 time unit after the edge.
module tb_tl_light_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  tl_light_monitor_if #(.CNT_W(8)) ifa ();
  tl_light_monitor_if #(.CNT_W(8)) ifb ();

  tl_light_monitor #(.MIN_DWELL(1), .MAX_DWELL(255), .CNT_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (ifa.slave)
  );

  tl_light_monitor #(.MIN_DWELL(2), .MAX_DWELL(3), .CNT_W(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (ifb.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // s is {red, yellow, green}
  task automatic step_a(input logic [2:0] s, input logic clr);
    {ifa.red_i, ifa.yellow_i, ifa.green_i} = s;
    ifa.clr_i = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic [2:0] s, input logic clr);
    {ifb.red_i, ifb.yellow_i, ifb.green_i} = s;
    ifb.clr_i = clr;
    @(posedge clk);
    #1;
  endtask

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  initial begin
    logic [2:0] nom_seq [7];
    logic [1:0] nom_ph  [7];
    nom_seq = '{R, G, Y, R, G, Y, R};
    nom_ph  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};

    {ifa.red_i, ifa.yellow_i, ifa.green_i, ifa.clr_i} = 4'b0;
    {ifb.red_i, ifb.yellow_i, ifb.green_i, ifb.clr_i} = 4'b0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", ifa.locked_o, 0);
    check("rst_phase", ifa.phase_o, 0);
    check("rst_dwell", ifa.dwell_o, 0);
    check("rst_cycles", ifa.cycles_o, 0);
    check("rst_err_onehot", ifa.err_onehot_o, 0);
    check("rst_err_seq", ifa.err_seq_o, 0);
    check("rst_err_dwell", ifa.err_dwell_o, 0);
    check("rst_err_any", ifa.err_any_o, 0);
    rst_n = 1'b1;

    // Nominal stream R,G,Y,R,G,Y,R
    for (int i = 0; i < 7; i++) begin
      step_a(nom_seq[i], 1'b0);
      check($sformatf("nom_locked_%0d", i), ifa.locked_o, 1);
      check($sformatf("nom_dwell_%0d", i), ifa.dwell_o, 1);
      check($sformatf("nom_phase_%0d", i), ifa.phase_o, nom_ph[i]);
    end
    check("nom_cycles", ifa.cycles_o, 2);
    check("nom_err_onehot", ifa.err_onehot_o, 0);
    check("nom_err_seq", ifa.err_seq_o, 0);
    check("nom_err_dwell", ifa.err_dwell_o, 0);
    step_a(R, 1'b0);
    check("nom_stay_dwell", ifa.dwell_o, 2);
    check("nom_err_any", ifa.err_any_o, 0);

    // One-hot fault: R,G,110
    step_a(R, 1'b0);
    step_a(G, 1'b0);
    step_a(3'b110, 1'b0);
    check("oh_err_onehot", ifa.err_onehot_o, 1);
    check("oh_locked", ifa.locked_o, 0);
    check("oh_dwell", ifa.dwell_o, 0);
    step_a(R, 1'b0);
    check("oh_err_any_lag", ifa.err_any_o, 1);
    check("oh_relock", ifa.locked_o, 1);
    check("oh_sticky", ifa.err_onehot_o, 1);

    // Sequence fault: R,Y
    step_a(R, 1'b0);
    step_a(Y, 1'b0);
    check("seq_err_seq", ifa.err_seq_o, 1);
    check("seq_phase", ifa.phase_o, 0);
    check("seq_locked", ifa.locked_o, 0);
    check("seq_cycles", ifa.cycles_o, 2);

    // Clear collision: clr with an illegal 000 sample
    step_a(3'b000, 1'b1);
    check("clr_col_onehot", ifa.err_onehot_o, 1);
    check("clr_col_seq", ifa.err_seq_o, 0);
    step_a(G, 1'b1);
    check("clr_onehot", ifa.err_onehot_o, 0);
    check("clr_seq", ifa.err_seq_o, 0);
    check("clr_dwell", ifa.err_dwell_o, 0);
    step_a(G, 1'b0);
    check("clr_err_any", ifa.err_any_o, 0);

    // Reset mid-GREEN
    step_a(R, 1'b0);
    step_a(G, 1'b0);
    check("mid_phase_green", ifa.phase_o, 1);
    rst_n = 1'b0;
    step_a(G, 1'b0);
    check("mrst_locked", ifa.locked_o, 0);
    check("mrst_phase", ifa.phase_o, 0);
    check("mrst_dwell", ifa.dwell_o, 0);
    check("mrst_cycles", ifa.cycles_o, 0);
    check("mrst_err_any", ifa.err_any_o, 0);
    rst_n = 1'b1;
    step_a(G, 1'b0);
    check("mrst_no_lock_on_g", ifa.locked_o, 0);
    step_a(R, 1'b0);
    check("mrst_relock", ifa.locked_o, 1);

    // Max dwell tracking: R x3, G, Y x2, R
    step_a(R, 1'b0);
    step_a(R, 1'b0);
    step_a(G, 1'b0);
    step_a(Y, 1'b0);
    step_a(Y, 1'b0);
    step_a(R, 1'b0);
    check("max_run_cycles", ifa.cycles_o, 1);
`ifdef TL_MON_MAXDWELL_EN
    check("max_red", ifa.max_red_o, 3);
    check("max_green", ifa.max_green_o, 1);
    check("max_yellow", ifa.max_yellow_o, 2);
`endif

    // Dwell limits on instance b (MIN 2, MAX 3)
    step_b(R, 1'b0);
    step_b(R, 1'b0);
    check("b_dwell_r2", ifb.dwell_o, 2);
    step_b(G, 1'b0);
    check("b_no_short_rg", ifb.err_dwell_o, 0);
    step_b(Y, 1'b0);
    check("b_short_gy", ifb.err_dwell_o, 1);
    step_b(Y, 1'b1);
    check("b_clr", ifb.err_dwell_o, 0);
    step_b(R, 1'b0);
    check("b_cycles", ifb.cycles_o, 1);
    step_b(R, 1'b0);
    step_b(R, 1'b0);
    check("b_no_over_3", ifb.err_dwell_o, 0);
    check("b_dwell_3", ifb.dwell_o, 3);
    step_b(R, 1'b0);
    check("b_over_4", ifb.err_dwell_o, 1);
    step_b(R, 1'b0);
    check("b_dwell_5", ifb.dwell_o, 5);
    check("b_locked", ifb.locked_o, 1);
    check("b_err_sticky", ifb.err_dwell_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
